// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, EX redirect flushes,
// and a hold-off FSM around a multi-cycle divide unit with a timeout watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             md_done,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_start,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MD_TIMEOUT - 1);

  typedef enum logic {StRun, StMdWait} state_t;

  state_t           state_q;
  logic [WaitW-1:0] wait_cnt_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       use_rs1, use_rs2;
  logic       load_use, is_div, timeout;

  logic stall_inc, flush_inc, go_wait, release_md, wait_inc, set_err;

  assign opcode = id_instr[6:0];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  assign is_div   = (opcode == 7'b0110011) && (id_instr[31:25] == 7'b0000001) && id_instr[14];
  assign timeout  = (wait_cnt_q == WaitLast);

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_start   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    go_wait    = 1'b0;
    release_md = 1'b0;
    wait_inc   = 1'b0;
    set_err    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (is_div) begin
          md_start   = 1'b1;
          idex_flush = 1'b1;
          go_wait    = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      StMdWait: begin
        // Redirects and new divides cannot occur here: EX only holds bubbles.
        if (md_done || timeout) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          release_md = 1'b1;
          set_err    = !md_done;
        end else begin
          idex_flush = 1'b1;
          wait_inc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      md_err     <= 1'b0;
    end else begin
      if (go_wait) begin
        state_q    <= StMdWait;
        wait_cnt_q <= '0;
      end
      if (release_md) state_q <= StRun;
      if (wait_inc) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (set_err) md_err <= 1'b1;
      // Counters saturate rather than wrap.
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued as each step is
// driven and popped when the DUT response is sampled.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   id_instr;
  logic          ex_memread;
  logic [4:0]    ex_rd;
  logic          ex_redirect;
  logic          md_done;
  logic          pc_we, ifid_we, ifid_flush, idex_flush, md_start, md_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.CNT_W(CW), .MD_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_instr   (id_instr),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .ex_redirect(ex_redirect),
    .md_done    (md_done),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .md_start   (md_start),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    outs;  // {pc_we, ifid_we, ifid_flush, idex_flush, md_start}
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  localparam logic [4:0] ORun   = 5'b11000;
  localparam logic [4:0] OFlush = 5'b11110;
  localparam logic [4:0] OStall = 5'b00010;
  localparam logic [4:0] OStart = 5'b00011;

  exp_t          exp_q[$];
  exp_t          cur;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] es = '0;
  logic [CW-1:0] ef = '0;
  logic          eerr = 1'b0;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  localparam logic [31:0] Nop = 32'h0000_0013;  // addi x0,x0,0

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic mr,
                      input logic [4:0] rd, input logic rdir, input logic done,
                      input logic [4:0] o, input logic inc_s, input logic inc_f,
                      input logic err_set);
    exp_t e;
    @(negedge clk);
    id_instr    = instr;
    ex_memread  = mr;
    ex_rd       = rd;
    ex_redirect = rdir;
    md_done     = done;
    if (inc_s && (es != '1)) es = es + 1'b1;
    if (inc_f && (ef != '1)) ef = ef + 1'b1;
    if (err_set) eerr = 1'b1;
    e.outs  = o;
    e.err   = eerr;
    e.stall = es;
    e.flush = ef;
    exp_q.push_back(e);
    #2;
    cur = exp_q.pop_front();
    chk({tag, ".outs"}, {27'b0, pc_we, ifid_we, ifid_flush, idex_flush, md_start},
        {27'b0, cur.outs});
    @(posedge clk);
    #1;
    chk({tag, ".stall_cnt"}, {28'b0, stall_cnt}, {28'b0, cur.stall});
    chk({tag, ".flush_cnt"}, {28'b0, flush_cnt}, {28'b0, cur.flush});
    chk({tag, ".md_err"}, {31'b0, md_err}, {31'b0, cur.err});
  endtask

  initial begin
    logic [31:0] add_657, add_675, add_100, addi_imm5, addi_x5, sw_x5, lui_x5, mul_i, div_i;
    add_657   = rtype(7'd0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011);
    add_675   = rtype(7'd0, 5'd5, 5'd7, 3'b000, 5'd6, 7'b0110011);
    add_100   = rtype(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011);
    addi_imm5 = {12'd5, 5'd2, 3'b000, 5'd1, 7'b0010011};
    addi_x5   = {12'd0, 5'd5, 3'b000, 5'd1, 7'b0010011};
    sw_x5     = rtype(7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011);
    lui_x5    = {12'h000, 5'd5, 3'b000, 5'd5, 7'b0110111};
    mul_i     = rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    div_i     = rtype(7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011);

    rst = 1'b1; id_instr = Nop; ex_memread = 1'b0; ex_rd = 5'd0;
    ex_redirect = 1'b0; md_done = 1'b0;
    #12;
    chk("reset.stall_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("reset.flush_cnt", {28'b0, flush_cnt}, 32'd0);
    chk("reset.md_err", {31'b0, md_err}, 32'd0);
    chk("reset.outs", {27'b0, pc_we, ifid_we, ifid_flush, idex_flush, md_start}, {27'b0, ORun});
    @(negedge clk);
    rst = 1'b0;

    step("redir_lu", add_657, 1, 5'd5, 1, 0, OFlush, 0, 1, 0);
    step("lu_rs1",   add_657, 1, 5'd5, 0, 0, OStall, 1, 0, 0);
    step("lu_clear", add_657, 0, 5'd5, 0, 0, ORun,   0, 0, 0);
    step("lu_rs2",   add_675, 1, 5'd5, 0, 0, OStall, 1, 0, 0);
    step("lw_x0",    add_100, 1, 5'd0, 0, 0, ORun,   0, 0, 0);
    step("addi_imm", addi_imm5, 1, 5'd5, 0, 0, ORun, 0, 0, 0);
    step("addi_rs1", addi_x5, 1, 5'd5, 0, 0, OStall, 1, 0, 0);
    step("sw_rs2",   sw_x5,   1, 5'd5, 0, 0, OStall, 1, 0, 0);
    step("lui",      lui_x5,  1, 5'd5, 0, 0, ORun,   0, 0, 0);
    step("redir",    Nop,     0, 5'd0, 1, 0, OFlush, 0, 1, 0);
    step("mul",      mul_i,   0, 5'd0, 0, 0, ORun,   0, 0, 0);

    // Divide finishing after 10 stalled wait cycles; redirect/done noise must be ignored.
    step("div_start", div_i, 0, 5'd0, 0, 0, OStart, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("div_wait", div_i, 0, 5'd0, 1, 0, OStall, 0, 0, 0);
    step("div_rel",   div_i, 0, 5'd0, 0, 1, ORun, 0, 0, 0);
    step("done_run",  Nop,   0, 5'd0, 0, 1, ORun, 0, 0, 0);

    // Divide that never completes: 63 stalled cycles, release on the 64th.
    step("to_start", div_i, 0, 5'd0, 0, 0, OStart, 0, 0, 0);
    for (int i = 0; i < 63; i++) step("to_wait", div_i, 0, 5'd0, 0, 0, OStall, 0, 0, 0);
    step("to_rel",   div_i, 0, 5'd0, 0, 0, ORun, 0, 0, 1);
    step("to_run",   Nop,   0, 5'd0, 0, 0, ORun, 0, 0, 0);

    // Reset pulse while waiting on a divide.
    step("rw_start", div_i, 0, 5'd0, 0, 0, OStart, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("rw_wait", div_i, 0, 5'd0, 0, 0, OStall, 0, 0, 0);
    @(negedge clk);
    id_instr = Nop;
    rst = 1'b1;
    #1;
    chk("rst_mw.stall_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("rst_mw.flush_cnt", {28'b0, flush_cnt}, 32'd0);
    chk("rst_mw.md_err", {31'b0, md_err}, 32'd0);
    chk("rst_mw.outs", {27'b0, pc_we, ifid_we, ifid_flush, idex_flush, md_start}, {27'b0, ORun});
    es = '0; ef = '0; eerr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", Nop, 0, 5'd0, 0, 0, ORun, 0, 0, 0);

    // Saturation of both counters.
    for (int i = 0; i < 17; i++) step("sat_stall", add_657, 1, 5'd5, 0, 0, OStall, 1, 0, 0);
    for (int i = 0; i < 17; i++) step("sat_flush", Nop, 0, 5'd0, 1, 0, OFlush, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-002 SHALL have parameter MD_TIMEOUT, default 64, maximum number of MD_WAIT cycles before abort.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 id_instr  input  32  instruction currently held in IF/ID.
REQ-006 ex_memread  input  1  instruction in EX is a load.
REQ-007 ex_rd  input  5  destination register of the instruction in EX.
REQ-008 ex_redirect  input  1  taken branch, JAL or JALR resolved in EX.
REQ-009 md_done  input  1  multi-cycle divide unit result valid; single-cycle pulse.
REQ-010 pc_we  output  1  PC write enable.
REQ-011 ifid_we  output  1  IF/ID register write enable.
REQ-012 ifid_flush  output  1  clears IF/ID to NOP.
REQ-013 idex_flush  output  1  loads a bubble into ID/EX.
REQ-014 md_start  output  1  one-cycle start pulse to the divide unit.
REQ-015 md_err  output  1  sticky divide-timeout flag.
REQ-016 stall_cnt  output  CNT_W  count of load-use stall cycles.
REQ-017 flush_cnt  output  CNT_W  count of redirect flushes.

Function
REQ-018 The block SHALL decode register use from id_instr[6:0] as follows.
- 0110011, 0100011 and 1100011 use rs1 ([19:15]) and rs2 ([24:20]).
- 0000011, 0010011 and 1100111 use rs1 only.
- 0110111, 0010111, 1101111 and all other opcodes use no source register.
REQ-019 A load-use hazard SHALL be defined as: ex_memread=1, ex_rd!=0, and ex_rd equals a used rs1 or rs2.
REQ-020 A divide op SHALL be defined as: opcode 0110011, funct7=0000001 and id_instr[14]=1 (DIV, DIVU, REM, REMU).
REQ-021 The FSM SHALL have two states, RUN and MD_WAIT; all outputs except the counters and md_err SHALL be combinational from the state and the inputs.
REQ-022 In RUN, priority 1: when ex_redirect=1, the outputs SHALL be pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, and flush_cnt SHALL increment; the FSM stays in RUN.
REQ-023 In RUN, priority 2: on a load-use hazard, the outputs SHALL be pc_we=0, ifid_we=0, idex_flush=1, and stall_cnt SHALL increment; the FSM stays in RUN.
REQ-024 In RUN, priority 3: on a divide op, the outputs SHALL be md_start=1, pc_we=0, ifid_we=0, idex_flush=1; the next state is MD_WAIT and the wait counter clears to 0.
REQ-025 In RUN with none of the above conditions, the outputs SHALL be pc_we=1 and ifid_we=1, with all flush and start outputs at 0.
REQ-026 In MD_WAIT while md_done=0, the outputs SHALL be pc_we=0, ifid_we=0, idex_flush=1, and the wait counter SHALL increment.
REQ-027 In MD_WAIT with md_done=1, the outputs SHALL be pc_we=1, ifid_we=1, idex_flush=0, and the next state is RUN; the divide op advances to EX in that cycle.
REQ-028 In MD_WAIT, if the wait counter reaches MD_TIMEOUT-1 with md_done=0, md_err SHALL set, the pipeline SHALL release as in REQ-027, and the next state is RUN.
REQ-029 ex_redirect and md_start SHALL be ignored in MD_WAIT; EX holds only bubbles in that state.
REQ-030 md_done received in RUN SHALL be ignored.
REQ-031 Both counters SHALL saturate at all-ones and never wrap.
REQ-032 md_start SHALL never be asserted in two consecutive cycles.

Reset
REQ-033 While rst=1, the block SHALL hold: state RUN, stall_cnt=0, flush_cnt=0, md_err=0, wait counter 0.
REQ-034 Asserting rst in MD_WAIT SHALL return the FSM to RUN immediately, with no further md_start until a new divide op is decoded.
REQ-035 md_err SHALL clear only on rst.

Verification
REQ-036 The bench SHALL cover: EX lw x5 with ID add x6,x5,x7 -> one cycle of pc_we=0, idex_flush=1, stall_cnt=1.
REQ-037 The bench SHALL cover: EX lw x0 with ID using x0 -> no stall, pc_we=1.
REQ-038 The bench SHALL cover: ex_redirect=1 together with a load-use hazard -> flush wins, ifid_flush=1, flush_cnt=1, stall_cnt=0.
REQ-039 The bench SHALL cover: ID div x3,x1,x2 -> md_start for 1 cycle; md_done 10 cycles later -> 10 stalled cycles, then release and RUN.
REQ-040 The bench SHALL cover: divide op with md_done never asserted -> md_err=1 after 64 MD_WAIT cycles, then RUN.
REQ-041 The bench SHALL cover: rst pulse in MD_WAIT -> RUN, counters 0, md_err 0.
